// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, register index width and
// the default mul/div completion timeout.
package pipeline_ctrl_pkg;

    localparam int unsigned RegIdxW          = 5;
    localparam int unsigned MdTimeoutDefault = 64;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StMdWait = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in Execute writes a register that the
// instruction in Decode reads. Register 0 is hard-wired and never creates a hazard.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [RegIdxW-1:0] rs1,
    input  logic [RegIdxW-1:0] rs2,
    input  logic [RegIdxW-1:0] rd,
    input  logic               mem_read,
    output logic               hit
);

    assign hit = mem_read & (rd != '0) & ((rd == rs1) | (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: branch flushes, load-use stalls and a two-state FSM that
// holds the pipe around a multi-cycle mul/div op with a completion timeout.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MdTimeoutDefault,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RegIdxW-1:0] RegSource1D,
    input  logic [RegIdxW-1:0] RegSource2D,
    input  logic [RegIdxW-1:0] RegDestinE,
    input  logic               MemReadE,
    input  logic               PCSrcE,
    input  logic               MdOpE,
    input  logic               MdDone,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushM,
    output logic               MdStart,
    output logic               MdError,
    output logic [CNT_W-1:0]   StallCount
);

    localparam int unsigned    TmoW   = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(MD_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_hit;
    logic             tmo_hit;

    load_use_detect u_load_use_detect (
        .rs1      (RegSource1D),
        .rs2      (RegSource2D),
        .rd       (RegDestinE),
        .mem_read (MemReadE),
        .hit      (lu_hit)
    );

    // A done pulse on the last allowed cycle counts as a normal completion.
    assign tmo_hit = (state_q == StMdWait) & ~MdDone & (tmo_q == TmoMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (!PCSrcE && !lu_hit && MdOpE) begin
                    state_d = StMdWait;
                end
            end
            StMdWait: begin
                if (MdDone || tmo_hit) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        MdStart = 1'b0;
        unique case (state_q)
            StRun: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (lu_hit) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (MdOpE) begin
                    MdStart = 1'b1;
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    FlushM  = 1'b1;
                end
            end
            StMdWait: begin
                if (!MdDone && !tmo_hit) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counter idles at zero in RUN, so every entry to MD_WAIT starts from zero.
    always_comb begin
        tmo_d = '0;
        if (state_q == StMdWait && !MdDone && !tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign err_d = err_q | tmo_hit;
    assign cnt_d = (StallF && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign MdError    = err_q;
    assign StallCount = cnt_q;

endmodule
